// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback queue: register index width,
// the hard-wired zero register, default geometry and the queued entry layout.
package wb_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned ZERO_REG  = 31;
  localparam int unsigned WB_WIDTH  = 64;
  localparam int unsigned WB_DEPTH  = 4;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [WB_WIDTH-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/wbq_match.sv
// Youngest-match search over the valid queue entries for one lookup index.
// Entries are walked oldest to youngest so the last match seen wins.
module wbq_match
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH    = WB_DEPTH,
  parameter int unsigned WIDTH    = WB_WIDTH,
  parameter int unsigned ZERO_REG = wb_pkg::ZERO_REG,
  localparam int unsigned PtrW    = $clog2(DEPTH),
  localparam int unsigned CntW    = PtrW + 1
) (
  input  logic [PtrW-1:0]      rd_ptr_i,
  input  logic [CntW-1:0]      count_i,
  input  logic [REG_IDX_W-1:0] ent_rd_i   [DEPTH],
  input  logic [WIDTH-1:0]     ent_data_i [DEPTH],
  input  logic [REG_IDX_W-1:0] query_i,
  output logic                 hit_o,
  output logic [WIDTH-1:0]     fwd_o
);

  logic [PtrW-1:0] slot;

  always_comb begin
    hit_o = 1'b0;
    fwd_o = '0;
    slot  = '0;
    if (query_i != REG_IDX_W'(ZERO_REG)) begin
      for (int unsigned age = 0; age < DEPTH; age++) begin
        slot = rd_ptr_i + PtrW'(age);
        if ((CntW'(age) < count_i) && (ent_rd_i[slot] == query_i)) begin
          hit_o = 1'b1;
          fwd_o = ent_data_i[slot];
        end
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// In-order writeback FIFO in front of the register file write port, with
// combinational forwarding of pending writes to two lookup ports.
module writeback_queue
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH    = WB_DEPTH,
  parameter int unsigned WIDTH    = WB_WIDTH,
  parameter int unsigned ZERO_REG = wb_pkg::ZERO_REG
) (
  input  logic                 Clk,
  input  logic                 Resetl,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [REG_IDX_W-1:0] InRd,
  input  logic [WIDTH-1:0]     InData,
  input  logic                 Hold,
  output logic                 RegWr,
  output logic [REG_IDX_W-1:0] RW,
  output logic [WIDTH-1:0]     BusW,
  input  logic [REG_IDX_W-1:0] QA,
  input  logic [REG_IDX_W-1:0] QB,
  output logic                 HitA,
  output logic                 HitB,
  output logic [WIDTH-1:0]     FwdA,
  output logic [WIDTH-1:0]     FwdB
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [CntW-1:0]      count_q, count_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [REG_IDX_W-1:0] rd_q   [DEPTH];
  logic [WIDTH-1:0]     data_q [DEPTH];
  logic                 push, pop, not_empty;

  always_comb begin
    not_empty = (count_q != '0);
    InReady   = (count_q != CntW'(DEPTH));
    // Zero-register results complete the handshake but never occupy a slot.
    push      = InValid && InReady && (InRd != REG_IDX_W'(ZERO_REG));
    pop       = not_empty && !Hold;
    RegWr     = pop;
    RW        = not_empty ? rd_q[rd_ptr_q] : '0;
    BusW      = not_empty ? data_q[rd_ptr_q] : '0;
    count_d   = count_q + CntW'(push) - CntW'(pop);
    rd_ptr_d  = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    wr_ptr_d  = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
  end

  always_ff @(posedge Clk) begin
    if (!Resetl) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage is not reset; occupancy alone decides which slots are meaningful.
  always_ff @(posedge Clk) begin
    if (push) begin
      rd_q[wr_ptr_q]   <= InRd;
      data_q[wr_ptr_q] <= InData;
    end
  end

  wbq_match #(
    .DEPTH    (DEPTH),
    .WIDTH    (WIDTH),
    .ZERO_REG (ZERO_REG)
  ) u_match_a (
    .rd_ptr_i   (rd_ptr_q),
    .count_i    (count_q),
    .ent_rd_i   (rd_q),
    .ent_data_i (data_q),
    .query_i    (QA),
    .hit_o      (HitA),
    .fwd_o      (FwdA)
  );

  wbq_match #(
    .DEPTH    (DEPTH),
    .WIDTH    (WIDTH),
    .ZERO_REG (ZERO_REG)
  ) u_match_b (
    .rd_ptr_i   (rd_ptr_q),
    .count_i    (count_q),
    .ent_rd_i   (rd_q),
    .ent_data_i (data_q),
    .query_i    (QB),
    .hit_o      (HitB),
    .fwd_o      (FwdB)
  );

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed vector table, hand-written multi-cycle
// sequences, and randomized traffic against a queue-based reference model.
module tb_writeback_queue;
  import wb_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Resetl;
  logic        InValid;
  logic        InReady;
  logic [4:0]  InRd;
  logic [63:0] InData;
  logic        Hold;
  logic        RegWr;
  logic [4:0]  RW;
  logic [63:0] BusW;
  logic [4:0]  QA, QB;
  logic        HitA, HitB;
  logic [63:0] FwdA, FwdB;

  int tests = 0;
  int fails = 0;

  wb_entry_t mq[$];

  always #5 Clk = ~Clk;

  writeback_queue #(
    .DEPTH    (DEPTH),
    .WIDTH    (64),
    .ZERO_REG (31)
  ) dut (
    .Clk     (Clk),
    .Resetl  (Resetl),
    .InValid (InValid),
    .InReady (InReady),
    .InRd    (InRd),
    .InData  (InData),
    .Hold    (Hold),
    .RegWr   (RegWr),
    .RW      (RW),
    .BusW    (BusW),
    .QA      (QA),
    .QB      (QB),
    .HitA    (HitA),
    .HitB    (HitB),
    .FwdA    (FwdA),
    .FwdB    (FwdB)
  );

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        hold;
    logic [4:0]  qa;
    logic        e_ready;
    logic        e_wr;
    logic [4:0]  e_rw;
    logic [63:0] e_bus;
    logic        e_hit_a;
    logic [63:0] e_fwd_a;
    logic        e_hit_b;
    logic [63:0] e_fwd_b;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic v, logic [4:0] rd, logic [63:0] data, logic hold,
                              logic [4:0] qa, logic r, logic w, logic [4:0] rw,
                              logic [63:0] bus, logic ha, logic [63:0] fa, logic hb,
                              logic [63:0] fb);
    vec_t t;
    t.v = v; t.rd = rd; t.data = data; t.hold = hold; t.qa = qa;
    t.e_ready = r; t.e_wr = w; t.e_rw = rw; t.e_bus = bus;
    t.e_hit_a = ha; t.e_fwd_a = fa; t.e_hit_b = hb; t.e_fwd_b = fb;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Resetl = 1'b0; InValid = 1'b0; Hold = 1'b0; InRd = '0; InData = '0; QA = '0; QB = '0;
    tick();
    Resetl = 1'b1;
    mq.delete();
  endtask

  // Youngest pending write to q, as {hit, data}.
  function automatic logic [64:0] model_lookup(input logic [4:0] q);
    if (q == 5'd31) return '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].rd == q) return {1'b1, mq[i].data};
    return '0;
  endfunction

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 7) == 0) return 5'd31;
    return 5'($urandom_range(0, 6));
  endfunction

  initial begin
    logic        exp_ready, exp_wr;
    logic [4:0]  exp_rw;
    logic [63:0] exp_bus;
    logic [64:0] la, lb;

    Resetl = 1'b0; InValid = 1'b0; Hold = 1'b0; InRd = '0; InData = '0; QA = '0; QB = '0;
    tick();
    tick();
    Resetl = 1'b1;

    // Directed table: single write latency, zero register, youngest-match forwarding.
    vecs[0]  = mk(0, 0,  64'h0,    0, 0,  1, 0, 0, 64'h0,    0, 64'h0,  0, 64'h0);
    vecs[1]  = mk(1, 5,  64'hAAAA, 0, 5,  1, 0, 0, 64'h0,    0, 64'h0,  0, 64'h0);
    vecs[2]  = mk(0, 0,  64'h0,    0, 5,  1, 1, 5, 64'hAAAA, 1, 64'hAAAA, 0, 64'h0);
    vecs[3]  = mk(0, 0,  64'h0,    0, 5,  1, 0, 0, 64'h0,    0, 64'h0,  0, 64'h0);
    vecs[4]  = mk(1, 31, 64'hFFFF, 0, 31, 1, 0, 0, 64'h0,    0, 64'h0,  0, 64'h0);
    vecs[5]  = mk(0, 0,  64'h0,    0, 31, 1, 0, 0, 64'h0,    0, 64'h0,  0, 64'h0);
    vecs[6]  = mk(1, 3,  64'h11,   1, 3,  1, 0, 0, 64'h0,    0, 64'h0,  0, 64'h0);
    vecs[7]  = mk(1, 3,  64'h22,   1, 3,  1, 0, 3, 64'h11,   1, 64'h11, 1, 64'h11);
    vecs[8]  = mk(0, 0,  64'h0,    1, 3,  1, 0, 3, 64'h11,   1, 64'h22, 1, 64'h22);
    vecs[9]  = mk(0, 0,  64'h0,    0, 3,  1, 1, 3, 64'h11,   1, 64'h22, 1, 64'h22);
    vecs[10] = mk(0, 0,  64'h0,    0, 3,  1, 1, 3, 64'h22,   1, 64'h22, 1, 64'h22);
    vecs[11] = mk(0, 0,  64'h0,    0, 3,  1, 0, 0, 64'h0,    0, 64'h0,  0, 64'h0);

    for (int i = 0; i < 12; i++) begin
      InValid = vecs[i].v; InRd = vecs[i].rd; InData = vecs[i].data;
      Hold = vecs[i].hold; QA = vecs[i].qa; QB = 5'd3;
      #1;
      check($sformatf("vec%0d InReady", i), 64'(InReady), 64'(vecs[i].e_ready));
      check($sformatf("vec%0d RegWr", i), 64'(RegWr), 64'(vecs[i].e_wr));
      check($sformatf("vec%0d RW", i), 64'(RW), 64'(vecs[i].e_rw));
      check($sformatf("vec%0d BusW", i), BusW, vecs[i].e_bus);
      check($sformatf("vec%0d HitA", i), 64'(HitA), 64'(vecs[i].e_hit_a));
      check($sformatf("vec%0d FwdA", i), FwdA, vecs[i].e_fwd_a);
      check($sformatf("vec%0d HitB", i), 64'(HitB), 64'(vecs[i].e_hit_b));
      check($sformatf("vec%0d FwdB", i), FwdB, vecs[i].e_fwd_b);
      tick();
    end

    // Fill under Hold, refuse a fifth entry, then drain in order.
    do_reset();
    Hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      InValid = 1'b1; InRd = 5'(i); InData = 64'(i * 256);
      tick();
    end
    InValid = 1'b0;
    #1;
    check("full InReady", 64'(InReady), 64'h0);
    InValid = 1'b1; InRd = 5'd9; InData = 64'h99;
    tick();
    InValid = 1'b0; QA = 5'd9;
    #1;
    check("fifth InReady", 64'(InReady), 64'h0);
    check("fifth not queued", 64'(HitA), 64'h0);
    Hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check($sformatf("drain%0d RegWr", i), 64'(RegWr), 64'h1);
      check($sformatf("drain%0d RW", i), 64'(RW), 64'(i));
      check($sformatf("drain%0d BusW", i), BusW, 64'(i * 256));
      tick();
    end
    check("drained RegWr", 64'(RegWr), 64'h0);

    // Full queue with a pending producer: pop first, accept on the next cycle.
    do_reset();
    Hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      InValid = 1'b1; InRd = 5'(i); InData = 64'(i);
      tick();
    end
    InValid = 1'b1; InRd = 5'd7; InData = 64'h77; Hold = 1'b0;
    #1;
    check("fullpop InReady", 64'(InReady), 64'h0);
    check("fullpop RegWr", 64'(RegWr), 64'h1);
    tick();
    check("afterpop InReady", 64'(InReady), 64'h1);
    check("afterpop RW", 64'(RW), 64'h2);
    tick();
    InValid = 1'b0;
    #1;
    check("accept RW", 64'(RW), 64'h3);
    tick();
    check("accept RW4", 64'(RW), 64'h4);
    tick();
    check("accept RW7", 64'(RW), 64'h7);
    check("accept BusW7", BusW, 64'h77);
    tick();
    check("accept empty", 64'(RegWr), 64'h0);

    // Reset wins over a queued backlog and a concurrent push.
    do_reset();
    Hold = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      InValid = 1'b1; InRd = 5'(i); InData = 64'(i);
      tick();
    end
    Resetl = 1'b0; InRd = 5'd8; InData = 64'h88; Hold = 1'b0;
    tick();
    Resetl = 1'b1; InValid = 1'b0; QA = 5'd1; QB = 5'd8;
    #1;
    check("rst RegWr", 64'(RegWr), 64'h0);
    check("rst InReady", 64'(InReady), 64'h1);
    check("rst RW", 64'(RW), 64'h0);
    check("rst HitA", 64'(HitA), 64'h0);
    check("rst HitB", 64'(HitB), 64'h0);
    check("rst FwdA", FwdA, 64'h0);

    // Randomized traffic against the queue model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      InValid = ($urandom_range(0, 9) < 6);
      Hold    = ($urandom_range(0, 9) < 3);
      InRd    = pick_reg();
      InData  = {$urandom, $urandom};
      QA      = pick_reg();
      QB      = pick_reg();
      #1;
      exp_ready = (mq.size() != DEPTH);
      exp_wr    = (mq.size() != 0) && !Hold;
      exp_rw    = (mq.size() != 0) ? mq[0].rd : '0;
      exp_bus   = (mq.size() != 0) ? mq[0].data : '0;
      la = model_lookup(QA);
      lb = model_lookup(QB);
      check("rnd InReady", 64'(InReady), 64'(exp_ready));
      check("rnd RegWr", 64'(RegWr), 64'(exp_wr));
      check("rnd RW", 64'(RW), 64'(exp_rw));
      check("rnd BusW", BusW, exp_bus);
      check("rnd HitA", 64'(HitA), 64'(la[64]));
      check("rnd FwdA", FwdA, la[63:0]);
      check("rnd HitB", 64'(HitB), 64'(lb[64]));
      check("rnd FwdB", FwdB, lb[63:0]);
      tick();
      if (exp_wr) mq.delete(0);
      if (InValid && exp_ready && InRd != 5'd31) mq.push_back('{rd: InRd, data: InData});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
